sa_matmul_ctrl: RTL and testbench
=================================

// Module: sa_matmul_ctrl
// PURPOSE
//  Sequencer for one systolic-array matmul pass: OUT(SxC) = X(SxK) * W(KxC).
//  Fetches X columns / W rows from two operand buffers, streams one beat per SA
//  PE-shift strobe, appends zero flush beats, frames the pass with START/END flags
//  and hands the SxC result to the downstream (softmax/accumulate) stage by valid/ready.
// PARAMETERS
//  D_W     16  element width, Q2.13 signed
//  S       16  SA rows
//  C       16  SA columns
//  K_MAX   64  max inner dimension (beats)
//  A_W     6   buffer address width, clog2(K_MAX)
// PORTS
//  I_CLK          in   1         clock
//  I_RST_N        in   1         async active-low reset
//  I_START        in   1         pass request pulse; sampled only in IDLE
//  I_K_LEN        in   A_W+1     inner dimension K, 0..K_MAX; sampled with I_START
//  O_BUSY         out  1         high in every state except IDLE
//  O_DONE         out  1         1-cycle pulse when result accepted (or K_LEN==0)
//  O_X_RD_EN      out  1         X buffer read strobe
//  O_X_RD_ADDR    out  A_W       X column index k
//  I_X_RD_DATA    in   S*D_W     X column, valid 1 clk after O_X_RD_EN
//  O_W_RD_EN      out  1         W buffer read strobe (same timing as X)
//  O_W_RD_ADDR    out  A_W       W row index k
//  I_W_RD_DATA    in   C*D_W     W row, valid 1 clk after O_W_RD_EN
//  O_SA_START     out  1         to SA I_START_FLAG, 1-cycle pulse
//  O_SA_END       out  1         to SA I_END_FLAG, 1-cycle pulse
//  O_SA_X         out  S*D_W     to SA I_X, registered
//  O_SA_W         out  C*D_W     to SA I_W, registered
//  I_SA_SHIFT     in   1         SA PE-shift strobe (1 clk high every 5 clks)
//  I_SA_OUT_VLD   in   1         SA result valid
//  I_SA_OUT       in   S*C*D_W   SA result
//  O_RES_VLD      out  1         result valid to downstream
//  I_RES_RDY      in   1         downstream ready
//  O_RES          out  S*C*D_W   latched result, stable while O_RES_VLD
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-pass aborts; no DONE.
//  FSM IDLE->PRIME->LOAD->FEED->FLUSH->ENDF->DRAIN->HOLD->IDLE.
//   IDLE : I_START & K_LEN==0 -> O_DONE pulse, stay IDLE. I_START & K_LEN>0 ->
//          latch K_LEN, assert X/W RD_EN addr 0 this cycle, go PRIME.
//   PRIME: one wait cycle; buffer data lands.
//   LOAD : O_SA_X/W <= rd data; O_SA_START=1 this cycle; beat=0; go FEED.
//   FEED : on I_SA_SHIFT (SA consumes O_SA_X/W): if beat<K-1 issue RD_EN
//          addr beat+1 same cycle, load O_SA_X/W next cycle; else load zeros,
//          flush=0, go FLUSH. beat++ per shift. Operands stable between shifts.
//   FLUSH: zeros on O_SA_X/W; count shifts; after S+C-1 shifts go ENDF.
//   ENDF : O_SA_END=1 one cycle; go DRAIN.
//   DRAIN: wait I_SA_OUT_VLD; on it latch O_RES, O_RES_VLD=1, go HOLD.
//   HOLD : VLD&RDY -> O_RES_VLD=0, O_DONE pulse, IDLE next cycle.
//  Read rule: at most one RD_EN per shift; total RD_EN pulses per pass == K.
//  I_START while BUSY ignored. I_K_LEN>K_MAX clamped to K_MAX.
//  I_SA_SHIFT outside FEED/FLUSH ignored. SHIFT in the LOAD cycle is counted
//  as beat 0 consumption (START and first operands presented together).
//  Shift period >=2 clks required (read latency 1 + register); spec period 5.
//  No arithmetic performed; data passed bit-exact.
// STRUCTURE
//  Shared package mha_pkg: D_W/S/C defaults, K_MAX, state enum localparams.
//  One sub-module: sa_op_fetch (RD_EN/addr gen + operand hold regs, zero
//  insert); FSM, counters and result handshake in the top.
// TESTING
//  S=C=4,K=4, X=I4, W rows 1..16 (Q2.13) -> O_RES==W, 4 RD_EN each, DONE once.
//  K=1, X all 0x2000(1.0), W all 0x1000(0.5) -> every O_RES element 0x1000.
//  K=0 start -> O_DONE 1 clk later, no SA_START, no RD_EN, BUSY stays 0.
//  I_RES_RDY low 20 clks in HOLD -> O_RES stable, VLD held, DONE on accept.
//  I_START pulsed during FEED -> ignored; beat/address sequence unchanged.
//  Reset asserted in FLUSH -> all outputs 0 async; next start runs cleanly.

Source files
------------

// File: rtl/mha_pkg.sv
// Shared sizing defaults and FSM state encoding for the systolic-array matmul sequencer.
package mha_pkg;

  localparam int unsigned D_W_DEF   = 16;
  localparam int unsigned S_DEF     = 16;
  localparam int unsigned C_DEF     = 16;
  localparam int unsigned K_MAX_DEF = 64;
  localparam int unsigned A_W_DEF   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_LOAD,
    ST_FEED,
    ST_FLUSH,
    ST_ENDF,
    ST_DRAIN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/sa_op_fetch.sv
// Operand fetch: drives X/W buffer reads and holds the operands presented to the SA.
module sa_op_fetch
  import mha_pkg::*;
#(
  parameter int unsigned D_W = D_W_DEF,
  parameter int unsigned S   = S_DEF,
  parameter int unsigned C   = C_DEF,
  parameter int unsigned A_W = A_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rd_req,
  input  logic [A_W-1:0]   i_rd_addr,
  input  logic             i_zero,
  output logic             o_x_rd_en,
  output logic [A_W-1:0]   o_x_rd_addr,
  input  logic [S*D_W-1:0] i_x_rd_data,
  output logic             o_w_rd_en,
  output logic [A_W-1:0]   o_w_rd_addr,
  input  logic [C*D_W-1:0] i_w_rd_data,
  output logic [S*D_W-1:0] o_sa_x,
  output logic [C*D_W-1:0] o_sa_w
);

  logic r_rd_pend;

  assign o_x_rd_en   = i_rd_req;
  assign o_x_rd_addr = i_rd_addr;
  assign o_w_rd_en   = i_rd_req;
  assign o_w_rd_addr = i_rd_addr;

  // Buffer data is valid the cycle after the strobe; capture it then so the
  // operands only change once per consumed beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pend <= 1'b0;
      o_sa_x    <= '0;
      o_sa_w    <= '0;
    end else begin
      r_rd_pend <= i_rd_req;
      if (i_zero) begin
        o_sa_x <= '0;
        o_sa_w <= '0;
      end else if (r_rd_pend) begin
        o_sa_x <= i_x_rd_data;
        o_sa_w <= i_w_rd_data;
      end
    end
  end

endmodule

// File: rtl/sa_matmul_ctrl.sv
// Sequencer for one systolic-array matmul pass: operand streaming, flush, framing
// and valid/ready hand-off of the result to the downstream stage.
module sa_matmul_ctrl
  import mha_pkg::*;
#(
  parameter int unsigned D_W   = D_W_DEF,
  parameter int unsigned S     = S_DEF,
  parameter int unsigned C     = C_DEF,
  parameter int unsigned K_MAX = K_MAX_DEF,
  parameter int unsigned A_W   = A_W_DEF
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_START,
  input  logic [A_W:0]       I_K_LEN,
  output logic               O_BUSY,
  output logic               O_DONE,
  output logic               O_X_RD_EN,
  output logic [A_W-1:0]     O_X_RD_ADDR,
  input  logic [S*D_W-1:0]   I_X_RD_DATA,
  output logic               O_W_RD_EN,
  output logic [A_W-1:0]     O_W_RD_ADDR,
  input  logic [C*D_W-1:0]   I_W_RD_DATA,
  output logic               O_SA_START,
  output logic               O_SA_END,
  output logic [S*D_W-1:0]   O_SA_X,
  output logic [C*D_W-1:0]   O_SA_W,
  input  logic               I_SA_SHIFT,
  input  logic               I_SA_OUT_VLD,
  input  logic [S*C*D_W-1:0] I_SA_OUT,
  output logic               O_RES_VLD,
  input  logic               I_RES_RDY,
  output logic [S*C*D_W-1:0] O_RES
);

  localparam int unsigned  F_W        = $clog2(S + C);
  localparam logic [A_W:0] K_MAX_L    = (A_W + 1)'(K_MAX);
  localparam logic [F_W-1:0] FLUSH_LAST = F_W'(S + C - 2);

  state_t               r_state;
  state_t               w_nxt;
  logic [A_W:0]         r_k;
  logic [A_W:0]         r_beat;
  logic [A_W:0]         w_k_in;
  logic [F_W-1:0]       r_flush;
  logic                 r_done;
  logic [S*C*D_W-1:0]   r_res;
  logic                 w_consume;
  logic                 w_last;
  logic                 w_rd_req;
  logic [A_W-1:0]       w_rd_addr;
  logic                 w_zero;
  logic                 w_sa_start;
  logic                 w_sa_end;

  assign w_k_in    = (I_K_LEN > K_MAX_L) ? K_MAX_L : I_K_LEN;
  // A shift seen in LOAD already consumes beat 0 (START and first operands coincide).
  assign w_consume = I_SA_SHIFT && ((r_state == ST_LOAD) || (r_state == ST_FEED));
  assign w_last    = (r_beat == r_k - 1'b1);

  always_comb begin
    w_nxt      = r_state;
    w_rd_req   = 1'b0;
    w_rd_addr  = '0;
    w_zero     = 1'b0;
    w_sa_start = 1'b0;
    w_sa_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (I_START && (w_k_in != '0)) begin
          w_rd_req = 1'b1;
          w_nxt    = ST_PRIME;
        end
      end
      ST_PRIME: w_nxt = ST_LOAD;
      ST_LOAD, ST_FEED: begin
        w_sa_start = (r_state == ST_LOAD);
        if (r_state == ST_LOAD) w_nxt = ST_FEED;
        if (w_consume) begin
          if (!w_last) begin
            w_rd_req  = 1'b1;
            w_rd_addr = r_beat[A_W-1:0] + 1'b1;
          end else begin
            w_zero = 1'b1;
            w_nxt  = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (I_SA_SHIFT && (r_flush == FLUSH_LAST)) w_nxt = ST_ENDF;
      end
      ST_ENDF: begin
        w_sa_end = 1'b1;
        w_nxt    = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (I_SA_OUT_VLD) w_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (I_RES_RDY) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_beat  <= '0;
      r_flush <= '0;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= ((r_state == ST_IDLE) && I_START && (w_k_in == '0)) ||
                 ((r_state == ST_HOLD) && I_RES_RDY);
      if ((r_state == ST_IDLE) && I_START) begin
        r_k    <= w_k_in;
        r_beat <= '0;
      end else if (w_consume && !w_last) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_zero) begin
        r_flush <= '0;
      end else if ((r_state == ST_FLUSH) && I_SA_SHIFT) begin
        r_flush <= r_flush + 1'b1;
      end
      if ((r_state == ST_DRAIN) && I_SA_OUT_VLD) r_res <= I_SA_OUT;
    end
  end

  assign O_BUSY     = (r_state != ST_IDLE);
  assign O_DONE     = r_done;
  assign O_SA_START = w_sa_start;
  assign O_SA_END   = w_sa_end;
  assign O_RES_VLD  = (r_state == ST_HOLD);
  assign O_RES      = r_res;

  sa_op_fetch #(
    .D_W (D_W),
    .S   (S),
    .C   (C),
    .A_W (A_W)
  ) u_fetch (
    .i_clk       (I_CLK),
    .i_rst_n     (I_RST_N),
    .i_rd_req    (w_rd_req),
    .i_rd_addr   (w_rd_addr),
    .i_zero      (w_zero),
    .o_x_rd_en   (O_X_RD_EN),
    .o_x_rd_addr (O_X_RD_ADDR),
    .i_x_rd_data (I_X_RD_DATA),
    .o_w_rd_en   (O_W_RD_EN),
    .o_w_rd_addr (O_W_RD_ADDR),
    .i_w_rd_data (I_W_RD_DATA),
    .o_sa_x      (O_SA_X),
    .o_sa_w      (O_SA_W)
  );

endmodule

// File: tb/tb_sa_matmul_ctrl.sv
// Bench for sa_matmul_ctrl (S=C=4): buffer + behavioural SA model, scoreboard of expected results.
module tb_sa_matmul_ctrl;

  localparam int unsigned D_W   = 16;
  localparam int unsigned S     = 4;
  localparam int unsigned C     = 4;
  localparam int unsigned K_MAX = 64;
  localparam int unsigned A_W   = 6;
  localparam int unsigned RW    = S * C * D_W;

  logic               I_CLK;
  logic               I_RST_N;
  logic               I_START;
  logic [A_W:0]       I_K_LEN;
  logic               O_BUSY;
  logic               O_DONE;
  logic               O_X_RD_EN;
  logic [A_W-1:0]     O_X_RD_ADDR;
  logic [S*D_W-1:0]   I_X_RD_DATA;
  logic               O_W_RD_EN;
  logic [A_W-1:0]     O_W_RD_ADDR;
  logic [C*D_W-1:0]   I_W_RD_DATA;
  logic               O_SA_START;
  logic               O_SA_END;
  logic [S*D_W-1:0]   O_SA_X;
  logic [C*D_W-1:0]   O_SA_W;
  logic               I_SA_SHIFT;
  logic               I_SA_OUT_VLD;
  logic [RW-1:0]      I_SA_OUT;
  logic               O_RES_VLD;
  logic               I_RES_RDY;
  logic [RW-1:0]      O_RES;

  sa_matmul_ctrl #(
    .D_W   (D_W),
    .S     (S),
    .C     (C),
    .K_MAX (K_MAX),
    .A_W   (A_W)
  ) dut (
    .I_CLK        (I_CLK),
    .I_RST_N      (I_RST_N),
    .I_START      (I_START),
    .I_K_LEN      (I_K_LEN),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE),
    .O_X_RD_EN    (O_X_RD_EN),
    .O_X_RD_ADDR  (O_X_RD_ADDR),
    .I_X_RD_DATA  (I_X_RD_DATA),
    .O_W_RD_EN    (O_W_RD_EN),
    .O_W_RD_ADDR  (O_W_RD_ADDR),
    .I_W_RD_DATA  (I_W_RD_DATA),
    .O_SA_START   (O_SA_START),
    .O_SA_END     (O_SA_END),
    .O_SA_X       (O_SA_X),
    .O_SA_W       (O_SA_W),
    .I_SA_SHIFT   (I_SA_SHIFT),
    .I_SA_OUT_VLD (I_SA_OUT_VLD),
    .I_SA_OUT     (I_SA_OUT),
    .O_RES_VLD    (O_RES_VLD),
    .I_RES_RDY    (I_RES_RDY),
    .O_RES        (O_RES)
  );

  logic [S*D_W-1:0] xmem [K_MAX];
  logic [C*D_W-1:0] wmem [K_MAX];
  logic [A_W-1:0]   addr_log [1024];
  logic [RW-1:0]    exp_q [$];

  int n_chk = 0;
  int n_pass = 0;
  int rd_cnt = 0;
  int st_cnt = 0;
  int en_cnt = 0;
  int dn_cnt = 0;
  int busy_cnt = 0;
  int shift_cnt = 0;
  int xw_err = 0;
  int acc [S][C];
  bit sa_act = 1'b0;
  int sa_tmr = 0;
  int sh_ph = 0;

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

  function automatic int qmul(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p >>> 13;
  endfunction

  function automatic logic [RW-1:0] ref_res(input int unsigned k);
    logic [RW-1:0] r;
    int a;
    r = '0;
    for (int unsigned s = 0; s < S; s++) begin
      for (int unsigned c = 0; c < C; c++) begin
        a = 0;
        for (int unsigned kk = 0; kk < k; kk++)
          a += qmul(xmem[kk][s*D_W +: D_W], wmem[kk][c*D_W +: D_W]);
        r[(s*C+c)*D_W +: D_W] = a[D_W-1:0];
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  // Buffers: registered read, data held until the next strobe.
  always @(posedge I_CLK) begin
    if (O_X_RD_EN) I_X_RD_DATA <= xmem[O_X_RD_ADDR];
    if (O_W_RD_EN) I_W_RD_DATA <= wmem[O_W_RD_ADDR];
  end

  // Free-running PE-shift strobe, one clock in five.
  always @(posedge I_CLK) begin
    #1;
    sh_ph = (sh_ph == 4) ? 0 : sh_ph + 1;
    I_SA_SHIFT = (sh_ph == 0);
  end

  // Monitor plus SA model: operands accumulated on every shift between START and END.
  always @(negedge I_CLK) begin
    if (!I_RST_N) begin
      sa_act = 1'b0;
      sa_tmr = 0;
      I_SA_OUT_VLD = 1'b0;
    end else begin
      if (O_X_RD_EN) begin
        addr_log[rd_cnt % 1024] = O_X_RD_ADDR;
        rd_cnt++;
      end
      if ((O_X_RD_EN !== O_W_RD_EN) || (O_X_RD_EN && (O_X_RD_ADDR !== O_W_RD_ADDR))) xw_err++;
      if (O_SA_START) st_cnt++;
      if (O_SA_END) en_cnt++;
      if (O_DONE) dn_cnt++;
      if (O_BUSY) busy_cnt++;
      if (I_SA_SHIFT) shift_cnt++;
      I_SA_OUT_VLD = 1'b0;
      if (sa_tmr > 0) begin
        sa_tmr--;
        if (sa_tmr == 0) begin
          for (int unsigned s = 0; s < S; s++)
            for (int unsigned c = 0; c < C; c++)
              I_SA_OUT[(s*C+c)*D_W +: D_W] = acc[s][c][D_W-1:0];
          I_SA_OUT_VLD = 1'b1;
        end
      end
      if (O_SA_START) begin
        sa_act = 1'b1;
        for (int unsigned s = 0; s < S; s++)
          for (int unsigned c = 0; c < C; c++) acc[s][c] = 0;
      end
      if (sa_act && I_SA_SHIFT) begin
        for (int unsigned s = 0; s < S; s++)
          for (int unsigned c = 0; c < C; c++)
            acc[s][c] += qmul(O_SA_X[s*D_W +: D_W], O_SA_W[c*D_W +: D_W]);
      end
      if (O_SA_END) begin
        sa_act = 1'b0;
        sa_tmr = 3;
      end
    end
  end

  task automatic fill_rand();
    for (int unsigned k = 0; k < K_MAX; k++) begin
      xmem[k] = {$urandom(), $urandom()};
      wmem[k] = {$urandom(), $urandom()};
    end
  endtask

  task automatic run_pass(input int unsigned klen, input int unsigned hold, input bit mid);
    int unsigned keff;
    int n, rb, sb, eb, db;
    bit pulsed, stable, ok;
    logic [RW-1:0] first;
    keff = (klen > K_MAX) ? K_MAX : klen;
    exp_q.push_back(ref_res(keff));
    rb = rd_cnt; sb = st_cnt; eb = en_cnt; db = dn_cnt;
    pulsed = 1'b0;
    step();
    I_START = 1'b1;
    I_K_LEN = (A_W+1)'(klen);
    step();
    I_START = 1'b0;
    I_K_LEN = 7'd3;
    n = 0;
    while (n < 3000) begin
      @(negedge I_CLK);
      if (O_RES_VLD) break;
      step();
      n++;
      I_START = mid && !pulsed && (rd_cnt - rb >= 2);
      if (I_START) pulsed = 1'b1;
    end
    I_START = 1'b0;
    chk("res_vld_seen", O_RES_VLD, 1);
    first = O_RES;
    stable = 1'b1;
    for (int unsigned i = 0; i < hold; i++) begin
      step();
      @(negedge I_CLK);
      if ((O_RES !== first) || !O_RES_VLD || O_DONE) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", stable, 1);
    step();
    I_RES_RDY = 1'b1;
    @(negedge I_CLK);
    chk("sb_level", exp_q.size(), 1);
    if (exp_q.size() > 0) chk("res", O_RES, exp_q.pop_front());
    step();
    I_RES_RDY = 1'b0;
    @(negedge I_CLK);
    chk("done_pulse", O_DONE, 1);
    chk("idle_after", {O_BUSY, O_RES_VLD}, 0);
    repeat (3) step();
    @(negedge I_CLK);
    chk("rd_count", rd_cnt - rb, keff);
    chk("start_count", st_cnt - sb, 1);
    chk("end_count", en_cnt - eb, 1);
    chk("done_count", dn_cnt - db, 1);
    ok = 1'b1;
    for (int unsigned i = 0; i < keff; i++)
      if (addr_log[(rb + i) % 1024] !== A_W'(i)) ok = 1'b0;
    chk("rd_addr_seq", ok, 1);
    chk("xw_rd_align", xw_err, 0);
  endtask

  initial begin
    int rb, sb, bb, db, n;
    I_RST_N = 1'b0;
    I_START = 1'b0;
    I_K_LEN = '0;
    I_RES_RDY = 1'b0;
    I_SA_SHIFT = 1'b0;
    I_SA_OUT_VLD = 1'b0;
    I_SA_OUT = '0;
    I_X_RD_DATA = '0;
    I_W_RD_DATA = '0;
    repeat (3) @(posedge I_CLK);
    @(negedge I_CLK);
    chk("rst_ctrl", {O_BUSY, O_DONE, O_SA_START, O_SA_END, O_X_RD_EN, O_W_RD_EN, O_RES_VLD}, 0);
    chk("rst_ops", {O_SA_X, O_SA_W}, 0);
    chk("rst_res", O_RES, 0);
    step();
    I_RST_N = 1'b1;

    // X = identity (1.0 on the diagonal), W rows hold raw 1..16 -> result equals W.
    for (int unsigned k = 0; k < K_MAX; k++) begin
      xmem[k] = '0;
      wmem[k] = '0;
    end
    for (int unsigned k = 0; k < 4; k++) begin
      xmem[k][k*D_W +: D_W] = 16'h2000;
      for (int unsigned c = 0; c < C; c++) wmem[k][c*D_W +: D_W] = D_W'(k*4 + c + 1);
    end
    run_pass(4, 0, 1'b0);

    // K=1, 1.0 * 0.5 -> every element 0.5.
    for (int unsigned s = 0; s < S; s++) xmem[0][s*D_W +: D_W] = 16'h2000;
    for (int unsigned c = 0; c < C; c++) wmem[0][c*D_W +: D_W] = 16'h1000;
    run_pass(1, 0, 1'b0);

    // K=0 completes immediately without touching the buffers or the SA.
    rb = rd_cnt; sb = st_cnt; bb = busy_cnt;
    step();
    I_START = 1'b1;
    I_K_LEN = '0;
    step();
    I_START = 1'b0;
    @(negedge I_CLK);
    chk("k0_done", O_DONE, 1);
    chk("k0_busy", O_BUSY, 0);
    step();
    @(negedge I_CLK);
    chk("k0_done_clr", O_DONE, 0);
    repeat (8) step();
    @(negedge I_CLK);
    chk("k0_no_rd", rd_cnt - rb, 0);
    chk("k0_no_start", st_cnt - sb, 0);
    chk("k0_busy_seen", busy_cnt - bb, 0);

    // Back-pressure, start ignored while busy, oversize K clamped.
    fill_rand();
    run_pass(5, 20, 1'b0);
    fill_rand();
    run_pass(4, 2, 1'b1);
    fill_rand();
    run_pass(100, 0, 1'b0);

    // Reset during FLUSH aborts the pass without DONE; the next pass is clean.
    fill_rand();
    rb = rd_cnt; db = dn_cnt;
    step();
    I_START = 1'b1;
    I_K_LEN = 7'd2;
    step();
    I_START = 1'b0;
    n = 0;
    while ((rd_cnt - rb < 2) && (n < 500)) begin
      @(negedge I_CLK);
      n++;
    end
    sb = shift_cnt;
    while ((shift_cnt - sb < 2) && (n < 1000)) begin
      @(negedge I_CLK);
      n++;
    end
    chk("flush_busy", O_BUSY, 1);
    #2;
    I_RST_N = 1'b0;
    #1;
    chk("arst_ctrl", {O_BUSY, O_DONE, O_SA_START, O_SA_END, O_X_RD_EN, O_W_RD_EN, O_RES_VLD}, 0);
    chk("arst_ops", {O_SA_X, O_SA_W}, 0);
    chk("arst_res", O_RES, 0);
    repeat (2) step();
    I_RST_N = 1'b1;
    repeat (3) step();
    @(negedge I_CLK);
    chk("abort_no_done", dn_cnt - db, 0);
    fill_rand();
    run_pass(3, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
